// File: rtl/factorial_ctrl.sv
// factorial_ctrl: sequences a 64x64 signed Booth multiplier to compute n!.
// Captures n on start, issues one multiply per loop index k = 2..n, and
// reports the final 128-bit product with overflow and multiplier-hang flags.
module factorial_ctrl #(
  parameter int unsigned MUL_TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic         clear,
  input  logic [63:0]  n,
  output logic         busy,
  output logic         done,
  output logic         overflow,
  output logic         timeout,
  output logic [127:0] result,
  output logic [63:0]  mul_multiplier,
  output logic [63:0]  mul_multiplicand,
  output logic         mul_op_start,
  output logic         mul_op_clear,
  input  logic         mul_op_done,
  input  logic [127:0] mul_result
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ISSUE,
    S_WAIT,
    S_CLEAR,
    S_DONE
  } state_t;

  localparam logic [7:0] WAIT_LIMIT = 8'(MUL_TIMEOUT);

  state_t        state;
  logic [127:0]  acc;
  logic [63:0]   k;
  logic [63:0]   n_r;
  logic [7:0]    wcnt;
  logic [7:0]    wcnt_nxt;
  logic          in_run;

  // Operands come straight from the loop registers; they only change in
  // WAIT (acc capture) and CLEAR (k step), never while the multiplier samples.
  assign mul_multiplier   = k;
  assign mul_multiplicand = acc[63:0];

  // Next value of the wait counter and whether a run is in flight.
  always_comb begin
    wcnt_nxt = wcnt + 8'd1;
    in_run   = (state == S_SETUP) || (state == S_ISSUE) ||
               (state == S_WAIT)  || (state == S_CLEAR);
  end

  // Controller FSM; all outputs registered. mul_op_start is raised on the
  // transition into ISSUE and mul_op_clear on the transition into CLEAR, so
  // each is high for exactly the cycle spent in that state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      overflow     <= 1'b0;
      timeout      <= 1'b0;
      result       <= '0;
      acc          <= 128'd1;
      k            <= '0;
      n_r          <= '0;
      wcnt         <= '0;
      mul_op_start <= 1'b0;
      mul_op_clear <= 1'b0;
    end else begin
      mul_op_start <= 1'b0;
      mul_op_clear <= 1'b0;
      if (clear && in_run) begin
        // Abort: one clear pulse to the multiplier, then IDLE. In CLEAR the
        // pulse is already on the wire, so it is not repeated.
        state        <= S_IDLE;
        busy         <= 1'b0;
        mul_op_clear <= (state != S_CLEAR);
      end else begin
        case (state)
          S_IDLE: begin
            if (start && !clear) begin
              n_r      <= n;
              acc      <= 128'd1;
              k        <= 64'd2;
              busy     <= 1'b1;
              done     <= 1'b0;
              overflow <= 1'b0;
              timeout  <= 1'b0;
              result   <= '0;
              state    <= S_SETUP;
            end
          end
          S_SETUP: begin
            if (n_r[63]) begin
              overflow <= 1'b1;
              busy     <= 1'b0;
              done     <= 1'b1;
              state    <= S_DONE;
            end else if (k > n_r) begin
              result   <= acc;
              busy     <= 1'b0;
              done     <= 1'b1;
              state    <= S_DONE;
            end else begin
              mul_op_start <= 1'b1;
              wcnt         <= '0;
              state        <= S_ISSUE;
            end
          end
          S_ISSUE: begin
            wcnt  <= '0;
            state <= S_WAIT;
          end
          S_WAIT: begin
            wcnt <= wcnt_nxt;
            if (mul_op_done) begin
              acc          <= mul_result;
              mul_op_clear <= 1'b1;
              state        <= S_CLEAR;
            end else if (wcnt_nxt == WAIT_LIMIT) begin
              timeout      <= 1'b1;
              mul_op_clear <= 1'b1;
              state        <= S_CLEAR;
            end
          end
          S_CLEAR: begin
            if (timeout) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_DONE;
            end else if (k == n_r) begin
              result <= acc;
              busy   <= 1'b0;
              done   <= 1'b1;
              state  <= S_DONE;
            end else if (|acc[127:63]) begin
              overflow <= 1'b1;
              result   <= acc;
              busy     <= 1'b0;
              done     <= 1'b1;
              state    <= S_DONE;
            end else begin
              k            <= k + 64'd1;
              mul_op_start <= 1'b1;
              state        <= S_ISSUE;
            end
          end
          S_DONE: begin
            if (clear) begin
              done     <= 1'b0;
              overflow <= 1'b0;
              timeout  <= 1'b0;
              state    <= S_IDLE;
            end
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_factorial_ctrl.sv
// tb_factorial_ctrl: scoreboard bench for factorial_ctrl with a simple
// behavioural multiplier that can be told to hang.
module tb_factorial_ctrl;

  localparam int unsigned TOUT = 40;
  localparam int unsigned TMUL = 5;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic         clear = 1'b0;
  logic [63:0]  n = '0;
  logic         busy, done, overflow, timeout;
  logic [127:0] result;
  logic [63:0]  mul_multiplier, mul_multiplicand;
  logic         mul_op_start, mul_op_clear;
  logic         mul_op_done = 1'b0;
  logic [127:0] mul_result = '0;

  factorial_ctrl #(.MUL_TIMEOUT(TOUT)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .clear(clear), .n(n),
    .busy(busy), .done(done), .overflow(overflow), .timeout(timeout),
    .result(result), .mul_multiplier(mul_multiplier),
    .mul_multiplicand(mul_multiplicand), .mul_op_start(mul_op_start),
    .mul_op_clear(mul_op_clear), .mul_op_done(mul_op_done),
    .mul_result(mul_result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] res;
    logic         ovf;
    logic         tmo;
    bit           chk_res;
  } exp_t;
  typedef struct {
    logic [63:0] k;
    logic [63:0] mc;
    bit          chk_mc;
  } op_t;

  exp_t expq[$];
  op_t  opq[$];
  exp_t e;
  op_t  o;

  int checks = 0;
  int errors = 0;
  int n_start = 0, n_clr = 0, overlap = 0;
  int cyc = 0, last_start_cyc = 0, last_clr_cyc = 0;
  bit hang = 1'b0;
  logic done_q = 1'b0;

  // Behavioural multiplier: samples operands on op_start, raises op_done
  // TMUL cycles later and holds it until op_clear.
  logic [63:0] ma, mb;
  logic        mactive = 1'b0;
  int          mcnt = 0;
  always @(posedge clk) begin
    if (!reset_n) begin
      mactive     <= 1'b0;
      mcnt        <= 0;
      mul_op_done <= 1'b0;
    end else if (mul_op_clear) begin
      mactive     <= 1'b0;
      mul_op_done <= 1'b0;
    end else if (mul_op_start) begin
      mactive <= 1'b1;
      mcnt    <= 0;
      ma      <= mul_multiplicand;
      mb      <= mul_multiplier;
    end else if (mactive && !mul_op_done && !hang) begin
      mcnt <= mcnt + 1;
      if (mcnt == int'(TMUL) - 1) begin
        mul_op_done <= 1'b1;
        mul_result  <= {64'd0, ma} * {64'd0, mb};
      end
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops expected operands on each op_start and expected results
  // on each rising edge of done.
  initial begin
    forever begin
      @(negedge clk);
      if (mul_op_start && mul_op_clear) overlap++;
      if (mul_op_start) begin
        n_start++;
        last_start_cyc = cyc;
        if (opq.size() == 0) begin
          checks++; errors++;
          $display("FAIL op_start_unexpected: got k=%0d expected no pulse", mul_multiplier);
        end else begin
          o = opq.pop_front();
          chk("op_k", {64'd0, mul_multiplier}, {64'd0, o.k});
          if (o.chk_mc) chk("op_mcand", {64'd0, mul_multiplicand}, {64'd0, o.mc});
        end
      end
      if (mul_op_clear) begin
        n_clr++;
        last_clr_cyc = cyc;
      end
      if (done && !done_q) begin
        if (expq.size() == 0) begin
          checks++; errors++;
          $display("FAIL done_unexpected: got done=1 expected 0");
        end else begin
          e = expq.pop_front();
          chk("done_overflow", {127'd0, overflow}, {127'd0, e.ovf});
          chk("done_timeout", {127'd0, timeout}, {127'd0, e.tmo});
          if (e.chk_res) chk("done_result", result, e.res);
        end
      end
      done_q = done;
    end
  end

  task automatic push_exp(input logic [127:0] r, input logic ov, input logic tm, input bit cr);
    exp_t x;
    x.res = r; x.ovf = ov; x.tmo = tm; x.chk_res = cr;
    expq.push_back(x);
  endtask

  task automatic push_op(input logic [63:0] kk, input logic [63:0] mc, input bit cm);
    op_t x;
    x.k = kk; x.mc = mc; x.chk_mc = cm;
    opq.push_back(x);
  endtask

  task automatic run(input logic [63:0] val, output int lat);
    @(posedge clk); #1;
    start = 1'b1; n = val;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (!done && lat < 5000) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL run_wait n=%0d: got no done expected done", val);
    end
  endtask

  task automatic do_clear();
    @(posedge clk); #1 clear = 1'b1;
    @(posedge clk); #1 clear = 1'b0;
    chk("clear_done", {127'd0, done}, 128'd0);
  endtask

  // Starts a run that hangs in WAIT and returns two cycles into WAIT.
  task automatic start_into_wait();
    int b;
    hang = 1'b1;
    push_op(64'd2, 64'd1, 1'b1);
    @(posedge clk); #1;
    start = 1'b1; n = 64'd5;
    @(posedge clk); #1;
    start = 1'b0;
    b = 0;
    while (!mul_op_start && b < 20) begin
      @(posedge clk); #1;
      b++;
    end
    if (!mul_op_start) begin
      checks++; errors++;
      $display("FAIL wait_issue: got no op_start expected op_start");
    end
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"}, {127'd0, busy}, 128'd0);
    chk({tag, "_done"}, {127'd0, done}, 128'd0);
    chk({tag, "_ovf"}, {127'd0, overflow}, 128'd0);
    chk({tag, "_tmo"}, {127'd0, timeout}, 128'd0);
    chk({tag, "_result"}, result, 128'd0);
    chk({tag, "_opstart"}, {127'd0, mul_op_start}, 128'd0);
    chk({tag, "_opclear"}, {127'd0, mul_op_clear}, 128'd0);
    chk({tag, "_k"}, {64'd0, mul_multiplier}, 128'd0);
    chk({tag, "_mcand"}, {64'd0, mul_multiplicand}, 128'd1);
  endtask

  initial begin
    int lat, s0, c0;

    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_idle_outputs("reset");
    reset_n = 1'b1;

    // n=5: four multiplies, 5! = 120
    push_op(64'd2, 64'd1, 1'b1);
    push_op(64'd3, 64'd2, 1'b1);
    push_op(64'd4, 64'd6, 1'b1);
    push_op(64'd5, 64'd24, 1'b1);
    push_exp(128'h78, 1'b0, 1'b0, 1'b1);
    s0 = n_start; c0 = n_clr;
    run(64'd5, lat);
    chk("n5_starts", 128'(n_start - s0), 128'd4);
    chk("n5_clears", 128'(n_clr - c0), 128'd4);
    // start while DONE is ignored
    @(posedge clk); #1; start = 1'b1; n = 64'd9;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("done_start_ignored", {127'd0, done}, 128'd1);
    chk("done_start_nops", 128'(n_start - s0), 128'd4);
    do_clear();

    // n=0 and n=1: no multiplies, 2-cycle latency
    s0 = n_start;
    push_exp(128'd1, 1'b0, 1'b0, 1'b1);
    run(64'd0, lat);
    chk("n0_latency", 128'(lat), 128'd2);
    do_clear();
    push_exp(128'd1, 1'b0, 1'b0, 1'b1);
    run(64'd1, lat);
    chk("n1_latency", 128'(lat), 128'd2);
    chk("n01_starts", 128'(n_start - s0), 128'd0);
    do_clear();

    // n=21: largest n whose result fits
    for (int i = 2; i <= 21; i++)
      push_op(64'(i), 64'h21C3677C82B40000, i == 21);
    push_exp(128'h2C5077D36B8C40000, 1'b0, 1'b0, 1'b1);
    run(64'd21, lat);
    do_clear();

    // n=22: stops after the 21st product with overflow
    s0 = n_start;
    for (int i = 2; i <= 21; i++) push_op(64'(i), 64'd0, 1'b0);
    push_exp(128'h2C5077D36B8C40000, 1'b1, 1'b0, 1'b1);
    run(64'd22, lat);
    repeat (4) begin @(posedge clk); #1; end
    chk("n22_starts", 128'(n_start - s0), 128'd20);
    do_clear();

    // operand with bit 63 set: overflow without any multiply
    s0 = n_start;
    push_exp(128'd0, 1'b1, 1'b0, 1'b0);
    run(64'h8000_0000_0000_0003, lat);
    chk("neg_latency", 128'(lat), 128'd2);
    chk("neg_starts", 128'(n_start - s0), 128'd0);
    do_clear();

    // multiplier hang -> timeout
    hang = 1'b1;
    c0 = n_clr;
    push_op(64'd2, 64'd1, 1'b1);
    push_exp(128'd0, 1'b0, 1'b1, 1'b0);
    run(64'd3, lat);
    chk("tmo_clears", 128'(n_clr - c0), 128'd1);
    chk("tmo_wait_len", 128'(last_clr_cyc - last_start_cyc), 128'(TOUT + 1));
    do_clear();
    hang = 1'b0;
    push_op(64'd2, 64'd1, 1'b1);
    push_op(64'd3, 64'd2, 1'b1);
    push_exp(128'd6, 1'b0, 1'b0, 1'b1);
    run(64'd3, lat);
    do_clear();

    // clear while in WAIT aborts
    c0 = n_clr;
    start_into_wait();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    chk("abort_opclear", {127'd0, mul_op_clear}, 128'd1);
    repeat (3) begin @(posedge clk); #1; end
    chk("abort_clears", 128'(n_clr - c0), 128'd1);
    chk("abort_busy", {127'd0, busy}, 128'd0);
    chk("abort_done", {127'd0, done}, 128'd0);

    // reset while in WAIT
    start_into_wait();
    reset_n = 1'b0;
    @(posedge clk); #1;
    chk_idle_outputs("wreset");
    reset_n = 1'b1;
    hang = 1'b0;
    repeat (3) begin @(posedge clk); #1; end

    chk("no_start_clear_overlap", 128'(overlap), 128'd0);
    chk("opq_empty", 128'(opq.size()), 128'd0);
    chk("expq_empty", 128'(expq.size()), 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/factorial_ctrl.md
Name: factorial_ctrl

Overview:
- Sequencing stage directly upstream and downstream of the 64x64 signed radix-4 Booth multiplier in the factorial machine.
- Accepts an operand n, computes n! by iterated multiplication, and hands the final 128-bit product to the top level.
- Drives the multiplier's operand, op_start and op_clear inputs, and consumes its op_done and result outputs.
- Detects operand overflow and multiplier hang.

Parameters:
- MUL_TIMEOUT, 255: maximum cycles spent waiting for multiplier op_done before aborting with an error. Range 32..255.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset_n  in  1  reset, synchronous, active-low.
- start  in  1  request to compute n!; sampled only in IDLE.
- clear  in  1  abort or acknowledge; returns the block to IDLE from any state.
- n  in  64  operand, unsigned; captured when start is accepted.
- busy  out  1  high from start acceptance until DONE is entered.
- done  out  1  level; high in DONE until clear.
- overflow  out  1  valid with done; the result was truncated because n! needed an operand wider than 63 bits.
- timeout  out  1  valid with done; the multiplier failed to raise op_done within MUL_TIMEOUT cycles.
- result  out  128  n!, valid while done=1 and overflow=timeout=0.
- mul_multiplier  out  64  multiplier operand (loop index k).
- mul_multiplicand  out  64  multiplicand operand (accumulator low 64 bits).
- mul_op_start  out  1  one-cycle start pulse to multiplier.
- mul_op_clear  out  1  one-cycle clear pulse to multiplier.
- mul_op_done  in  1  multiplier completion (level).
- mul_result  in  128  multiplier product.

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - State goes to IDLE.
  - busy, done, overflow, timeout, mul_op_start and mul_op_clear are 0.
  - result = 0, acc = 1, k = 0, wait counter = 0.
  - Reset mid-operation abandons the run; the multiplier shares reset_n and is reset by it.
- Registers: acc[127:0], k[63:0], n_r[63:0], wcnt[7:0]. mul_multiplicand = acc[63:0], mul_multiplier = k.
- States: IDLE, SETUP, ISSUE, WAIT, CLEAR, DONE.
- IDLE:
  - On start=1, capture n into n_r; set acc=1, k=2, busy=1; go to SETUP.
  - clear=1 in the same cycle as start wins: the block stays in IDLE.
- SETUP:
  - If n_r[63]=1: overflow=1, go to DONE.
  - Else if k > n_r (covers n = 0, 1): result = acc, go to DONE.
  - Else go to ISSUE.
- ISSUE:
  - mul_op_start=1 for exactly this cycle; operands are stable this cycle (the multiplier samples them in its IDLE).
  - wcnt=0; go to WAIT.
- WAIT:
  - Operands are held constant and wcnt increments.
  - On mul_op_done=1: capture acc = mul_result, then go to CLEAR.
  - On wcnt reaching MUL_TIMEOUT without mul_op_done: timeout=1, go to CLEAR (acc unchanged).
- CLEAR:
  - mul_op_clear=1 for exactly this cycle; the multiplier returns to IDLE next cycle.
  - If timeout=1, go to DONE.
  - Else if k == n_r: result = acc, go to DONE.
  - Else if acc[127:63] != 0: overflow=1, result = acc, go to DONE (the next operand would be negative or truncated).
  - Else k = k+1, go to ISSUE; this gives the multiplier its required IDLE cycle.
- DONE: busy=0, done=1; result, overflow and timeout are held. clear=1 goes to IDLE and drops done next cycle.
- clear in SETUP, ISSUE, WAIT or CLEAR aborts:
  - Go to DONE-free IDLE via one cycle with mul_op_clear=1 (the multiplier must not be left in EXECUTE).
  - done is never raised for an aborted run.
- start outside IDLE is ignored.
- mul_op_start and mul_op_clear are never high in the same cycle.
- Arithmetic: all operands are positive signed 64-bit values, so the signed product equals the unsigned product. The final product may use all 128 bits; intermediate acc must fit in 63 bits.
- Latency: for n ≥ 2, 2 + (n−1)·(3 + Tmul) cycles from start to done, where Tmul is the multiplier's start-to-op_done time. For n ≤ 1, 2 cycles.

Test Plan:
- n=5, start pulse → exactly 4 mul_op_start pulses with k=2,3,4,5; done=1, result=0x78, overflow=0, timeout=0; each mul_op_clear is one cycle after its op_done.
- n=0, then n=1 → done 2 cycles after start, result=1, no mul_op_start pulse.
- n=21 → result=0x2C5077D36B8C40000; before the last multiply, mul_multiplicand=0x21C3677C82B40000 and mul_multiplier=21; overflow=0.
- n=22 → after the 21st product, acc[127:63]≠0: done=1, overflow=1, result=0x2C5077D36B8C40000, no further mul_op_start.
- Multiplier model holds mul_op_done=0 → timeout=1 and done=1 after MUL_TIMEOUT wait cycles, one mul_op_clear pulse. Then clear → IDLE; a new start with n=3 gives result=6.
- clear asserted in WAIT, and separately reset_n=0 in WAIT → one mul_op_clear pulse, then IDLE with busy=done=0 (clear case); all outputs zero next cycle (reset case).
